// File: rtl/regfile_nport.sv
// Parametrised register file: one write port, NRD combinational read ports,
// one-hot write decode, optional zero register, optional write bypass and a sticky out-of-range flag.
module regfile_nport #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NREGS-1:0]    wsel,
  output logic                oob_err,
  input  logic                err_clr
);

  // One extra bit so NREGS itself is representable when it is a power of two.
  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [XLEN-1:0] regs [NREGS];
  logic [NRD-1:0]  rd_oob;
  logic            wr_oob;

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      wsel[i] = we && (waddr == AW'(i)) && !(ZERO_REG != 0 && i == 0);
    end
  end

  assign wr_oob = we && ({1'b0, waddr} >= NREGS_W);

  // An out-of-range address matches no register, so it falls through to zero.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] val;

    assign addr      = raddr[k*AW +: AW];
    assign rd_oob[k] = ({1'b0, addr} >= NREGS_W);

    always_comb begin
      val = '0;
      for (int i = 0; i < NREGS; i++) begin
        if (addr == AW'(i)) begin
          if (ZERO_REG != 0 && i == 0) begin
            val = '0;
          end else if (BYPASS != 0 && wsel[i]) begin
            val = wdata;
          end else begin
            val = regs[i];
          end
        end
      end
    end

    assign rdata[k*XLEN +: XLEN] = val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wsel[i]) begin
          regs[i] <= wdata;
        end
      end
    end
  end

  // Set takes priority over clear so a fault in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oob_err <= 1'b0;
    end else if (wr_oob || (|rd_oob)) begin
      oob_err <= 1'b1;
    end else if (err_clr) begin
      oob_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_nport.sv
// Bench for regfile_nport: a default instance (32 regs, 2 ports, bypass) and a
// 24-register, 4-port, no-bypass instance share the write side; a model feeds a scoreboard.
module tb_regfile_nport;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         we;
  logic [4:0]   waddr;
  logic [31:0]  wdata;
  logic         err_clr;
  logic [9:0]   raddr_a;
  logic [63:0]  rdata_a;
  logic [31:0]  wsel_a;
  logic         oob_a;
  logic [19:0]  raddr_b;
  logic [127:0] rdata_b;
  logic [23:0]  wsel_b;
  logic         oob_b;

  regfile_nport dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr_a), .rdata(rdata_a), .wsel(wsel_a), .oob_err(oob_a), .err_clr(err_clr)
  );

  regfile_nport #(.NREGS(24), .NRD(4), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr_b), .rdata(rdata_b), .wsel(wsel_b), .oob_err(oob_b), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ma [32];
  logic [31:0] mb [24];
  logic        ob;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got %h, expected an entry", obs);
    end else begin
      e = sb.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  function automatic logic [31:0] exp_a(input int a);
    if (a >= 32 || a == 0) return 32'h0;
    if (we && int'(waddr) == a) return wdata;
    return ma[a];
  endfunction

  function automatic logic [31:0] exp_b(input int a);
    if (a >= 24 || a == 0) return 32'h0;
    return mb[a];
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 32; i++) ma[i] = 32'h0;
    for (int i = 0; i < 24; i++) mb[i] = 32'h0;
    ob = 1'b0;
  endfunction

  // Push expectations for every combinational output, let them settle, then compare.
  task automatic compare_comb();
    logic [31:0] ews_a;
    logic [31:0] ews_b;
    ews_a = (we && waddr != 0) ? (32'h1 << waddr) : 32'h0;
    ews_b = (we && waddr != 0 && waddr < 24) ? (32'h1 << waddr) : 32'h0;
    sb.push_back('{"rd_a0", exp_a(int'(raddr_a[4:0]))});
    sb.push_back('{"rd_a1", exp_a(int'(raddr_a[9:5]))});
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{$sformatf("rd_b%0d", k), exp_b(int'(raddr_b[k*5 +: 5]))});
    end
    sb.push_back('{"wsel_a", ews_a});
    sb.push_back('{"wsel_b", ews_b});
    #1;
    check_pop(rdata_a[31:0]);
    check_pop(rdata_a[63:32]);
    for (int k = 0; k < 4; k++) check_pop(rdata_b[k*32 +: 32]);
    check_pop(wsel_a);
    check_pop({8'h0, wsel_b});
  endtask

  task automatic compare_oob();
    sb.push_back('{"oob_a", 32'h0});
    sb.push_back('{"oob_b", {31'h0, ob}});
    check_pop({31'h0, oob_a});
    check_pop({31'h0, oob_b});
  endtask

  // One full cycle: drive after negedge, check combinational outputs, advance model at posedge.
  task automatic apply(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] b0, input logic [4:0] b1,
                       input logic [4:0] b2, input logic [4:0] b3, input logic clr);
    logic set_b;
    @(negedge clk);
    we = w; waddr = wa; wdata = wd; err_clr = clr;
    raddr_a = {a1, a0};
    raddr_b = {b3, b2, b1, b0};
    compare_comb();
    @(posedge clk);
    set_b = (w && wa >= 24) || b0 >= 24 || b1 >= 24 || b2 >= 24 || b3 >= 24;
    if (rst_n) begin
      if (w && wa != 0) ma[wa] = wd;
      if (w && wa != 0 && wa < 24) mb[wa] = wd;
      if (set_b) ob = 1'b1;
      else if (clr) ob = 1'b0;
    end
    #1;
    compare_oob();
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; err_clr = 1'b0;
    raddr_a = '0; raddr_b = '0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_comb();
    compare_oob();

    // Fill registers 1..31 while reading the target back (bypass on a, stored on b).
    for (int i = 1; i < 32; i++) begin
      apply(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'(i), 5'(i), 5'(i), 5'(i), 5'(i), 1'b0);
    end
    for (int i = 0; i < 32; i++) begin
      apply(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i), 5'(31 - i), 5'(31 - i), 5'(i), 1'b0);
    end

    apply(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    apply(1'b0, 5'd0, 32'h0, 5'd0, 5'd1, 5'd0, 5'd1, 5'd0, 5'd0, 1'b0);

    apply(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd3, 5'd7, 5'd3, 5'd7, 5'd7, 1'b0);
    apply(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 1'b0);

    for (int w = 0; w < 32; w++) begin
      apply(1'b1, 5'(w), $urandom, 5'(w), 5'd9, 5'd2, 5'd9, 5'd11, 5'd2, 1'b0);
    end
    for (int w = 0; w < 32; w += 5) begin
      apply(1'b0, 5'(w), $urandom, 5'(w), 5'd1, 5'd1, 5'd2, 5'd3, 5'd4, 1'b0);
    end

    // Out-of-range handling on the 24-register instance.
    apply(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd1, 5'd2, 5'd3, 5'd4, 1'b1);
    apply(1'b1, 5'd27, 32'hCAFEF00D, 5'd27, 5'd1, 5'd1, 5'd2, 5'd3, 5'd4, 1'b0);
    apply(1'b0, 5'd0, 32'h0, 5'd27, 5'd1, 5'd27, 5'd2, 5'd3, 5'd4, 1'b0);
    apply(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd1, 5'd2, 5'd3, 5'd4, 1'b1);
    apply(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd1, 5'd27, 5'd3, 5'd4, 1'b1);
    apply(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 5'd1, 5'd2, 5'd3, 5'd4, 1'b0);
    apply(1'b1, 5'd23, 32'h0BADF00D, 5'd23, 5'd24, 5'd23, 5'd1, 5'd1, 5'd1, 1'b1);

    apply(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 5'd5, 5'd9, 5'd13, 5'd5, 1'b0);

    // Asynchronous reset mid-cycle, then writes held off while reset is low.
    apply(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 1'b0);
    apply(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    clear_model();
    compare_comb();
    compare_oob();
    we = 1'b1; waddr = 5'd5; wdata = 32'hAAAA5555;
    compare_comb();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b0;
    apply(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
